isa_posted_bridge: RTL

//  Parametrised ISA slave front end for the video cards. It synchronises the ISA strobes and decodes one I/O window and
//  one memory window. CPU VRAM writes are posted into a FIFO so the CPU does not stall on display fetch slots. VRAM

---
 rtl/isa_bridge_pkg.sv | 29 ++
 rtl/isa_posted_bridge_fifo.sv | 53 +++++
 rtl/isa_posted_bridge.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/isa_bridge_pkg.sv
// Shared types and helpers for the ISA posted-write bridge.
package isa_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_STALL = 3'd1,
    RD_DRAIN = 3'd2,
    RD_REQ   = 3'd3,
    RD_WAIT  = 3'd4,
    RD_HOLD  = 3'd5
  } state_t;

  localparam logic [7:0] TIMEOUT_DATA = 8'hFF;

  // Posted-write entry is {window offset, data byte}.
  function automatic int entry_width(input int win_log2);
    return win_log2 + 8;
  endfunction

  // Compare only the bits above the window size; bases are aligned.
  function automatic logic win_match(input logic [19:0] addr,
                                     input logic [19:0] base,
                                     input int          span_log2);
    logic [19:0] mask;
    mask = ~((20'd1 << span_log2) - 20'd1);
    return ((addr ^ base) & mask) == 20'd0;
  endfunction

endpackage

// File: rtl/isa_posted_bridge_fifo.sv
// Small synchronous FIFO holding posted VRAM writes; level-based full/empty.
module sync_fifo #(
  parameter int WIDTH = 23,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok = push & (~full | pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/isa_posted_bridge.sv
// ISA slave front end: strobe sync, I/O and memory window decode, posted VRAM
// writes through a FIFO, and stalled VRAM reads with RAW ordering and timeout.
//
// state    | meaning
// IDLE     | no bus op in progress; FIFO head issued if present
// WR_STALL | FIFO full on a write; bus held, entry pushed on first free slot
// RD_DRAIN | read seen; waiting for queued writes to retire
// RD_REQ   | read request on mem_* until accepted
// RD_WAIT  | waiting for read data or timeout
// RD_HOLD  | data presented, bus released until memr deasserts
module isa_posted_bridge
  import isa_bridge_pkg::*;
#(
  parameter logic [19:0] IO_BASE_ADDR  = 20'h003D0,
  parameter int          IO_SPAN_LOG2  = 4,
  parameter logic [19:0] MEM_BASE_ADDR = 20'hB8000,
  parameter int          MEM_WIN_LOG2  = 15,
  parameter int          FIFO_DEPTH    = 4,
  parameter int          USE_BUS_WAIT  = 1,
  parameter int          READ_TIMEOUT  = 63
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [19:0]                   bus_a,
  input  logic [7:0]                    bus_d,
  input  logic                          bus_ior_l,
  input  logic                          bus_iow_l,
  input  logic                          bus_memr_l,
  input  logic                          bus_memw_l,
  input  logic                          bus_aen,
  output logic [7:0]                    bus_out,
  output logic                          bus_dir,
  output logic                          bus_rdy,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [MEM_WIN_LOG2-1:0]       mem_addr,
  output logic [7:0]                    mem_wdata,
  input  logic                          mem_ack,
  input  logic [7:0]                    mem_rdata,
  input  logic                          mem_rvalid,
  output logic                          io_wr,
  output logic [IO_SPAN_LOG2-1:0]       io_addr,
  output logic [7:0]                    io_wdata,
  input  logic [7:0]                    io_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int ENT_W = entry_width(MEM_WIN_LOG2);
  localparam int CNT_W = $clog2(READ_TIMEOUT + 1);

  state_t                   state, state_nx;
  logic [2:0]               sync1, sync2, sync3;
  logic [2:0]               fall;
  logic                     memr_high;
  logic                     io_cs, mem_cs;
  logic                     iow_edge, memw_edge, memr_edge;
  logic [MEM_WIN_LOG2-1:0]  mem_offset;
  logic                     push, pop, room, full, empty, wr_issue;
  logic [ENT_W-1:0]         push_data, head, pend_entry;
  logic [MEM_WIN_LOG2-1:0]  rd_addr;
  logic [7:0]               rd_data;
  logic [CNT_W-1:0]         cnt;
  logic                     tmo, ovf_set, rd_load, rd_timeout;

  // Strobe bits: [2] memw, [1] memr, [0] iow. ior only steers the data bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
      sync3 <= '1;
    end else begin
      sync1 <= {bus_memw_l, bus_memr_l, bus_iow_l};
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign fall      = sync3 & ~sync2;
  assign memr_high = sync2[1];

  assign io_cs      = win_match(bus_a, IO_BASE_ADDR, IO_SPAN_LOG2) & ~bus_aen;
  assign mem_cs     = win_match(bus_a, MEM_BASE_ADDR, MEM_WIN_LOG2);
  assign mem_offset = bus_a[MEM_WIN_LOG2-1:0];
  assign iow_edge   = fall[0] & io_cs;
  assign memr_edge  = fall[1] & mem_cs;
  assign memw_edge  = fall[2] & mem_cs;

  assign bus_dir = (io_cs & ~bus_ior_l) | (mem_cs & ~bus_memr_l);

  always_comb begin
    bus_out = 8'h00;
    if (io_cs & ~bus_ior_l)        bus_out = io_rdata;
    else if (mem_cs & ~bus_memr_l) bus_out = rd_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      io_wr    <= 1'b0;
      io_addr  <= '0;
      io_wdata <= '0;
    end else begin
      io_wr <= iow_edge;
      if (iow_edge) begin
        io_addr  <= bus_a[IO_SPAN_LOG2-1:0];
        io_wdata <= bus_d;
      end
    end
  end

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .level     (fifo_level),
    .full      (full),
    .empty     (empty)
  );

  // Writes keep draining while a read waits for RAW ordering.
  assign wr_issue = (state == IDLE || state == WR_STALL || state == RD_DRAIN) && !empty;
  assign pop      = wr_issue & mem_ack;
  assign room     = ~full | pop;
  assign tmo      = (cnt == '0);

  assign mem_req   = wr_issue | (state == RD_REQ);
  assign mem_we    = wr_issue;
  assign mem_addr  = wr_issue ? head[ENT_W-1:8] : rd_addr;
  assign mem_wdata = head[7:0];
  assign bus_rdy   = !(state == WR_STALL || state == RD_DRAIN ||
                       state == RD_REQ   || state == RD_WAIT);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    push       = 1'b0;
    push_data  = {mem_offset, bus_d};
    ovf_set    = 1'b0;
    rd_load    = 1'b0;
    rd_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (memw_edge) begin
          if (room)                   push     = 1'b1;
          else if (USE_BUS_WAIT != 0) state_nx = WR_STALL;
          else                        ovf_set  = 1'b1;
        end else if (memr_edge) begin
          state_nx = RD_DRAIN;
        end
      end
      WR_STALL: begin
        if (room) begin
          push      = 1'b1;
          push_data = pend_entry;
          state_nx  = IDLE;
        end
      end
      default: begin
        if (memw_edge) begin
          if (room) push    = 1'b1;
          else      ovf_set = 1'b1;
        end
        case (state)
          RD_DRAIN: if (empty && !push) state_nx = RD_REQ;
          RD_REQ: begin
            if (tmo) begin
              rd_load    = 1'b1;
              rd_timeout = 1'b1;
              state_nx   = RD_HOLD;
            end else if (mem_ack) begin
              state_nx = RD_WAIT;
            end
          end
          RD_WAIT: begin
            if (mem_rvalid) begin
              rd_load  = 1'b1;
              state_nx = RD_HOLD;
            end else if (tmo) begin
              rd_load    = 1'b1;
              rd_timeout = 1'b1;
              state_nx   = RD_HOLD;
            end
          end
          RD_HOLD: if (memr_high) state_nx = IDLE;
          default: state_nx = IDLE;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow   <= 1'b0;
      pend_entry <= '0;
      rd_addr    <= '0;
      rd_data    <= 8'h00;
      cnt        <= '0;
    end else begin
      if (ovf_set) overflow <= 1'b1;
      if (state == IDLE && memw_edge && !room) pend_entry <= {mem_offset, bus_d};
      if (state == IDLE && memr_edge) rd_addr <= mem_offset;
      // Loaded one short so the terminal compare lands READ_TIMEOUT cycles after mem_req.
      if (state != RD_REQ && state_nx == RD_REQ) cnt <= CNT_W'(READ_TIMEOUT - 1);
      else if (cnt != '0)                        cnt <= cnt - 1'b1;
      if (rd_load) rd_data <= rd_timeout ? TIMEOUT_DATA : mem_rdata;
    end
  end

endmodule
